mp_engine_ctrl: RTL
===================

Name: mp_engine_ctrl

Overview:
- Per-engine sequencer directly upstream of the memcopy read master (and its write-master sibling).
- Takes a software start from the action register bank and shadows the run configuration so the masters see stable values for the whole run.
- Issues the one-cycle engine_start_pulse, waits for the read/write done pulses, and reports completion, errors, timeout/abort and per-direction cycle counts back to the register bank.

Parameters:
CNT_WIDTH, 32, width of rd/wr cycle counters and timeout counter

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
reg_start  in  1  one-cycle start request from register bank
reg_abort  in  1  one-cycle abort request
reg_clear  in  1  one-cycle clear of done/status
reg_timeout_limit  in  CNT_WIDTH  RUN-cycle limit; 0 disables timeout
reg_wrap_mode  in  1  configuration to shadow
reg_wrap_len  in  4  configuration to shadow
reg_source_address  in  64  configuration to shadow
reg_rd_init_data  in  32  configuration to shadow
reg_rd_pattern  in  32  configuration to shadow
reg_rd_number  in  32  configuration to shadow
reg_wr_number  in  32  write burst count (shadowed; wr pattern/address handled by write path)
engine_start_pulse  out  1  one-cycle launch to read/write masters
wrap_mode, wrap_len, source_address, rd_init_data, rd_pattern, rd_number, wr_number  out  as inputs  shadowed copies
rd_done_pulse  in  1  from read master
rd_error  in  2  from read master
wr_done_pulse  in  1  from write master
wr_error  in  2  from write master
busy  out  1  high in LAUNCH/RUN
done  out  1  sticky completion flag
status  out  8  [1:0] rd_error, [3:2] wr_error, [4] timeout, [5] aborted, [7:6] 0
rd_cycles  out  CNT_WIDTH  cycles from launch to rd_done_pulse
wr_cycles  out  CNT_WIDTH  cycles from launch to wr_done_pulse

Behaviour:
- Reset: state IDLE; all outputs 0, including shadow registers, counters, status, done, busy and engine_start_pulse.
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE/DONE, reg_start=1:
  - Capture all reg_* config into shadow outputs.
  - Clear done, status, rd_cycles and wr_cycles.
  - Go to LAUNCH.
  - reg_start and reg_clear together: start wins.
- LAUNCH (exactly 1 cycle):
  - engine_start_pulse=1.
  - rd_fin <= (rd_number==0); wr_fin <= (wr_number==0).
  - Timeout counter <= 0.
  - Go to RUN.
  - Latency: reg_start at cycle t gives engine_start_pulse at t+1 and shadow outputs valid from t+1.
- RUN:
  - Each cycle, rd_cycles increments while !rd_fin; wr_cycles increments while !wr_fin; timeout counter increments.
  - rd_done_pulse sets rd_fin and ORs rd_error into status[1:0]. The cycle in which the pulse arrives still increments, so done N cycles after engine_start_pulse gives rd_cycles=N. Same rule for the write side.
  - Exit to DONE when:
    - both fins are set (including the fin set this cycle), or
    - reg_timeout_limit!=0 and the timeout counter reaches limit-1 (sets status[4]), or
    - reg_abort=1 (sets status[5]).
  - Priority when coinciding: completion > abort > timeout. Completion still records any error bits.
  - Both numbers zero: RUN lasts one cycle, then DONE with rd_cycles=wr_cycles=0.
  - reg_start in LAUNCH/RUN is ignored: no re-capture, no pulse.
- DONE:
  - done=1, busy=0; counters and status hold.
  - reg_clear alone clears done and status and returns to IDLE. Counters hold until the next start.
- Done/error pulses outside RUN are ignored.
- Shadow outputs are written only on an accepted start.
- Abort and timeout do not reset the masters. Software must assert the block reset before the next start if the masters may still be active.
- Counters saturate at all-ones and do not wrap.
- Async reset mid-run returns everything to reset values immediately. No engine_start_pulse is emitted on reset release.

Test Plan:
- rd_number=4, wr_number=0, reg_start at t, rd_done_pulse at t+21 -> engine_start_pulse at t+1 only; done=1 at t+22; rd_cycles=20, wr_cycles=0, status=0.
- rd_number=8, wr_number=8, wr_done at launch+5, rd_done at launch+9 with rd_error=2'b10 -> done after the rd pulse; wr_cycles=5, rd_cycles=9, status=8'h02.
- rd_number=0, wr_number=0 -> launch pulse, done 2 cycles after launch; counters 0.
- reg_timeout_limit=16, no done pulses -> DONE after 16 RUN cycles; status[4]=1; rd_cycles=16; rd_done_pulse arriving later leaves status/counters unchanged.
- reg_start repeated during RUN with a changed reg_source_address -> no second pulse; source_address keeps the first value.
- reg_abort in the same cycle as the final rd_done_pulse -> status[5]=0, completion recorded.
- rst_n asserted mid-RUN -> busy/done/counters 0 asynchronously.
- reg_start and reg_clear together in DONE -> new run launches.

Source files
------------

// File: rtl/mp_engine_ctrl.sv
// Per-engine run sequencer: shadows the run configuration, launches the read/write masters,
// then collects done/error pulses, timeout/abort and per-direction cycle counts for software.
module mp_engine_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 reg_start,
    input  logic                 reg_abort,
    input  logic                 reg_clear,
    input  logic [CNT_WIDTH-1:0] reg_timeout_limit,
    input  logic                 reg_wrap_mode,
    input  logic [3:0]           reg_wrap_len,
    input  logic [63:0]          reg_source_address,
    input  logic [31:0]          reg_rd_init_data,
    input  logic [31:0]          reg_rd_pattern,
    input  logic [31:0]          reg_rd_number,
    input  logic [31:0]          reg_wr_number,
    output logic                 engine_start_pulse,
    output logic                 wrap_mode,
    output logic [3:0]           wrap_len,
    output logic [63:0]          source_address,
    output logic [31:0]          rd_init_data,
    output logic [31:0]          rd_pattern,
    output logic [31:0]          rd_number,
    output logic [31:0]          wr_number,
    input  logic                 rd_done_pulse,
    input  logic [1:0]           rd_error,
    input  logic                 wr_done_pulse,
    input  logic [1:0]           wr_error,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           status,
    output logic [CNT_WIDTH-1:0] rd_cycles,
    output logic [CNT_WIDTH-1:0] wr_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state;
    state_t                 state_nxt;
    logic                   rd_fin;
    logic                   wr_fin;
    logic [CNT_WIDTH-1:0]   tmo_cnt;
    logic [5:0]             status_q;

    logic accept_start;
    logic all_fin;
    logic tmo_hit;
    logic set_abort;
    logic set_tmo;
    logic clear_only;

    // Completion counts a fin arriving this very cycle, so it can beat abort/timeout.
    assign all_fin      = (rd_fin | rd_done_pulse) & (wr_fin | wr_done_pulse);
    assign tmo_hit      = (reg_timeout_limit != '0) && (tmo_cnt == reg_timeout_limit - CNT_ONE);
    assign accept_start = reg_start && ((state == S_IDLE) || (state == S_DONE));
    assign clear_only   = (state == S_DONE) && reg_clear && !reg_start;
    assign set_abort    = (state == S_RUN) && !all_fin && reg_abort;
    assign set_tmo      = (state == S_RUN) && !all_fin && !reg_abort && tmo_hit;
    assign status       = {2'b00, status_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        engine_start_pulse = 1'b0;
        busy               = 1'b0;
        done               = 1'b0;
        case (state)
            S_IDLE: begin
                if (reg_start) state_nxt = S_LAUNCH;
            end
            S_LAUNCH: begin
                engine_start_pulse = 1'b1;
                busy               = 1'b1;
                state_nxt          = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (all_fin || reg_abort || tmo_hit) state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (reg_start) begin
                    state_nxt = S_LAUNCH;
                end else if (reg_clear) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_mode      <= 1'b0;
            wrap_len       <= '0;
            source_address <= '0;
            rd_init_data   <= '0;
            rd_pattern     <= '0;
            rd_number      <= '0;
            wr_number      <= '0;
            rd_fin         <= 1'b0;
            wr_fin         <= 1'b0;
            tmo_cnt        <= '0;
            status_q       <= '0;
            rd_cycles      <= '0;
            wr_cycles      <= '0;
        end else begin
            if (accept_start) begin
                wrap_mode      <= reg_wrap_mode;
                wrap_len       <= reg_wrap_len;
                source_address <= reg_source_address;
                rd_init_data   <= reg_rd_init_data;
                rd_pattern     <= reg_rd_pattern;
                rd_number      <= reg_rd_number;
                wr_number      <= reg_wr_number;
                status_q       <= '0;
                rd_cycles      <= '0;
                wr_cycles      <= '0;
            end
            if (clear_only) status_q <= '0;

            if (state == S_LAUNCH) begin
                rd_fin  <= (rd_number == '0);
                wr_fin  <= (wr_number == '0);
                tmo_cnt <= '0;
            end

            if (state == S_RUN) begin
                if (!rd_fin && (rd_cycles != '1)) rd_cycles <= rd_cycles + CNT_ONE;
                if (!wr_fin && (wr_cycles != '1)) wr_cycles <= wr_cycles + CNT_ONE;
                if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + CNT_ONE;
                if (rd_done_pulse) begin
                    rd_fin        <= 1'b1;
                    status_q[1:0] <= status_q[1:0] | rd_error;
                end
                if (wr_done_pulse) begin
                    wr_fin        <= 1'b1;
                    status_q[3:2] <= status_q[3:2] | wr_error;
                end
                if (set_tmo)   status_q[4] <= 1'b1;
                if (set_abort) status_q[5] <= 1'b1;
            end
        end
    end

endmodule
